// File: rtl/bcd_display_ctrl_pkg.sv
// Shared types and constants for the binary-to-BCD converter and 7-segment scanner.
package bcd_display_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_ITER = 3'd7;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/add3.sv
// Shift-and-add-3 correction cell: adds 3 to a BCD nibble that is 5 or more.
module add3 (
  input  logic [3:0] a,
  output logic [3:0] y
);

  assign y = (a >= 4'd5) ? a + 4'd3 : a;

endmodule

// File: rtl/bcd_seg7_decode.sv
// BCD digit to active-low 7-segment pattern, with a forced-blank input.
module bcd_seg7_decode
  import bcd_display_ctrl_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Sequential binary-to-BCD converter with latched digits and a 4-digit
// common-anode display scanner with leading-zero blanking.
module bcd_display_ctrl
  import bcd_display_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [1:0] hundreds,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  // Handshake: load is taken only while busy is low (IDLE); a load seen while
  // busy is high is dropped, not queued. done pulses once with valid digits.

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t           state;
  logic [7:0]       bin;
  logic [9:0]       bcd;
  logic [CNT_W-1:0] iter;
  logic             shifted_all;
  logic [3:0]       ones_c;
  logic [3:0]       tens_c;

  add3 u_add3_ones (.a(bcd[3:0]), .y(ones_c));
  add3 u_add3_tens (.a(bcd[7:4]), .y(tens_c));

  // The final shift lands one cycle before the digits are latched, so the
  // latch reads a settled accumulator on the way into DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      bin         <= '0;
      bcd         <= '0;
      iter        <= '0;
      shifted_all <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ones        <= '0;
      tens        <= '0;
      hundreds    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (load) begin
            bin         <= value;
            bcd         <= '0;
            iter        <= '0;
            shifted_all <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (!shifted_all) begin
            bcd  <= {bcd[8], tens_c, ones_c, bin[7]};
            bin  <= {bin[6:0], 1'b0};
            iter <= iter + 3'd1;
            if (iter == LAST_ITER) shifted_all <= 1'b1;
          end else begin
            ones     <= bcd[3:0];
            tens     <= bcd[7:4];
            hundreds <= bcd[9:8];
            done     <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit_idx;
  logic [1:0]        next_idx;
  logic              scan_wrap;
  logic [3:0]        dec_digit;
  logic              dec_blank;
  logic [6:0]        dec_seg;

  assign scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign next_idx  = scan_wrap ? digit_idx + 2'd1 : digit_idx;
  assign dp        = 1'b1;

  // Decode for the slot that will be shown after this edge, so an and seg
  // always move together and fresh digits show up one edge after latching.
  always_comb begin
    dec_digit = ones;
    dec_blank = 1'b0;
    case (next_idx)
      2'd0: begin
        dec_digit = ones;
        dec_blank = 1'b0;
      end
      2'd1: begin
        dec_digit = tens;
        dec_blank = (hundreds == 2'd0) && (tens == 4'd0);
      end
      2'd2: begin
        dec_digit = {2'b00, hundreds};
        dec_blank = (hundreds == 2'd0);
      end
      default: begin
        dec_digit = 4'd0;
        dec_blank = 1'b1;
      end
    endcase
  end

  bcd_seg7_decode u_decode (
    .digit (dec_digit),
    .blank (dec_blank),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
      an        <= 4'b1110;
      seg       <= SEG_0;
    end else begin
      scan_cnt  <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
      digit_idx <= next_idx;
      an        <= ~(4'b0001 << next_idx);
      seg       <= dec_seg;
    end
  end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Self-checking bench for bcd_display_ctrl: conversion scoreboard, latency,
// ignored loads, mid-conversion reset and display scan/blanking.
module tb_bcd_display_ctrl;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] value;
  logic       load;
  logic       busy;
  logic       done;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [1:0] hundreds;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];
  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  bcd_display_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .busy     (busy),
    .done     (done),
    .ones     (ones),
    .tens     (tens),
    .hundreds (hundreds),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] exp_seg(input int idx, input logic [1:0] h,
                                         input logic [3:0] t, input logic [3:0] o);
    logic [3:0] hx;
    hx = {2'b00, h};
    case (idx)
      0:       return seg_tab[o];
      1:       return (h == 2'd0 && t == 4'd0) ? 7'h7F : seg_tab[t];
      2:       return (h == 2'd0) ? 7'h7F : seg_tab[hx];
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int idx_of_an(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Drives one load and follows it to completion; the expected digits are
  // queued here and popped when done is observed.
  task automatic run_conv(input logic [7:0] v, input bit check_timing,
                          input int inject_at, input logic [7:0] inject_v);
    int done_at;
    int n_busy;
    int n_done;
    logic [9:0] exp;
    logic [9:0] got;
    exp_q.push_back({2'(v / 100), 4'((v / 10) % 10), 4'(v % 10)});
    value = v;
    load = 1'b1;
    tick();
    load = 1'b0;
    done_at = -1;
    n_busy = 0;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      load = (i == inject_at);
      if (i == inject_at) value = inject_v;
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = i;
        checks++;
        got = {hundreds, tens, ones};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result_%0d: done with empty expected queue, got %0h", v, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL result_%0d: got %0h expected %0h", v, got, exp);
          end
        end
      end
      if (!busy) break;
      tick();
    end
    load = 1'b0;
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL done_count_%0d: got %0d expected 1", v, n_done);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_end_%0d: got %0b expected 0", v, busy);
    end
    if (check_timing) begin
      checks++;
      if (done_at !== 9) begin
        errors++;
        $display("FAIL done_latency_%0d: got %0d expected 9", v, done_at);
      end
      checks++;
      if (n_busy !== 10) begin
        errors++;
        $display("FAIL busy_cycles_%0d: got %0d expected 10", v, n_busy);
      end
    end
  endtask

  task automatic check_display(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o);
    int idx;
    logic [6:0] es;
    tick();
    for (int i = 0; i < 16; i++) begin
      idx = idx_of_an(an);
      checks++;
      if (idx < 0) begin
        errors++;
        $display("FAIL an_onehot: got %b expected one low bit", an);
      end else begin
        es = exp_seg(idx, h, t, o);
        checks++;
        if (seg !== es) begin
          errors++;
          $display("FAIL seg_digit%0d (%0d%0d%0d): got %h expected %h", idx, h, t, o, seg, es);
        end
      end
      checks++;
      if (dp !== 1'b1) begin
        errors++;
        $display("FAIL dp: got %b expected 1", dp);
      end
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    load = 1'b0;
    value = 8'd0;
    #12;
    checks++;
    if ({busy, done, hundreds, tens, ones} !== 12'h000) begin
      errors++;
      $display("FAIL reset_fsm: got %h expected 000", {busy, done, hundreds, tens, ones});
    end
    checks++;
    if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
      errors++;
      $display("FAIL reset_display: got %b expected 1110_1000000_1", {an, seg, dp});
    end
    tick();
    reset = 1'b0;
  endtask

  // Starts right after reset release: scan counter 0, digit 0, digits all 0.
  task automatic test_scan;
    logic [3:0] ea;
    logic [6:0] es;
    for (int i = 0; i < 20; i++) begin
      ea = ~(4'b0001 << ((i / 4) % 4));
      es = exp_seg((i / 4) % 4, 2'd0, 4'd0, 4'd0);
      checks++;
      if (an !== ea) begin
        errors++;
        $display("FAIL scan_an_%0d: got %b expected %b", i, an, ea);
      end
      checks++;
      if (seg !== es) begin
        errors++;
        $display("FAIL scan_seg_%0d: got %h expected %h", i, seg, es);
      end
      tick();
    end
  endtask

  task automatic test_ignored_load;
    int extra;
    run_conv(8'd42, 1'b1, 3, 8'd99);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy || done) extra++;
      tick();
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignored_load_restart: got %0d busy cycles expected 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    run_conv(8'd42, 1'b0, -1, 8'd0);
    run_conv(8'd99, 1'b1, -1, 8'd0);
  endtask

  task automatic test_reset_mid;
    int n_done;
    exp_q.push_back(10'h200);
    value = 8'd200;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    reset = 1'b1;
    #2;
    exp_q.pop_back();
    checks++;
    if ({busy, done, hundreds, tens, ones} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid: got %h expected 000", {busy, done, hundreds, tens, ones});
    end
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", n_done);
    end
    run_conv(8'd200, 1'b1, -1, 8'd0);
    check_display(2'd2, 4'd0, 4'd0);
  endtask

  initial begin
    test_reset();
    test_scan();
    run_conv(8'd255, 1'b1, -1, 8'd0);
    check_display(2'd2, 4'd5, 4'd5);
    run_conv(8'd0, 1'b1, -1, 8'd0);
    check_display(2'd0, 4'd0, 4'd0);
    run_conv(8'd7, 1'b0, -1, 8'd0);
    check_display(2'd0, 4'd0, 4'd7);
    run_conv(8'd100, 1'b0, -1, 8'd0);
    check_display(2'd1, 4'd0, 4'd0);
    test_ignored_load();
    test_back_to_back();
    for (int n = 0; n < 6; n++) begin
      logic [7:0] rv;
      rv = 8'($urandom_range(0, 255));
      run_conv(rv, 1'b1, -1, 8'd0);
    end
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
